// File: rtl/nes_pkg.sv
// Shared NES bus constants and the OAM DMA state encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package nes_pkg;

    // CPU address that starts an OAM DMA transfer
    localparam logic [15:0] DMA_REG      = 16'h4014;
    // PPU OAMDATA port, the destination of every DMA byte
    localparam logic [15:0] OAMDATA_REG  = 16'h2004;
    // Base of the memory-mapped PPU register window
    localparam logic [15:0] PPU_REG_BASE = 16'h2000;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: a write to DMA_REG halts the CPU and copies page P ($PP00-$PPFF) to OAMDATA.
// Latency: rdy falls the cycle after the trigger; 513 halted cycles, 514 with the alignment cycle.
// Backpressure: CPU is held via rdy; a CPU write in progress extends HALT until cpu_we drops.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG     = nes_pkg::DMA_REG,
    parameter logic [15:0] OAMDATA_REG = nes_pkg::OAMDATA_REG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [7:0]  bus_din,
    output logic        rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_we,
    output logic [7:0]  dma_dout
);

    dma_state_t  state_q;
    logic [7:0]  page_q;
    logic [7:0]  idx_q;
    logic [7:0]  data_q;
    logic        odd_q;
    logic        trig;

    // A CPU write to the DMA register; only acted on while idle
    assign trig = cpu_we && (cpu_addr == DMA_REG);

    // Transfer sequencer: trigger, halt, optional parity alignment, then read/write pairs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
            odd_q   <= 1'b0;
        end else begin
            odd_q <= ~odd_q;
            case (state_q)
                DMA_IDLE: begin
                    if (trig) begin
                        page_q  <= cpu_dout;
                        idx_q   <= 8'h00;
                        state_q <= DMA_HALT;
                    end
                end
                DMA_HALT: begin
                    // Never freeze the CPU in the middle of a write cycle
                    if (!cpu_we) begin
                        state_q <= odd_q ? DMA_ALIGN : DMA_READ;
                    end
                end
                DMA_ALIGN: begin
                    state_q <= DMA_READ;
                end
                DMA_READ: begin
                    data_q  <= bus_din;
                    state_q <= DMA_WRITE;
                end
                DMA_WRITE: begin
                    idx_q   <= idx_q + 8'h01;
                    state_q <= (idx_q == 8'hFF) ? DMA_IDLE : DMA_READ;
                end
                default: begin
                    state_q <= DMA_IDLE;
                end
            endcase
        end
    end

    // Moore output decode from the registered state, page, index and data
    always_comb begin
        rdy        = 1'b0;
        dma_active = 1'b0;
        dma_addr   = 16'h0000;
        dma_we     = 1'b0;
        dma_dout   = 8'h00;
        case (state_q)
            DMA_IDLE: begin
                rdy = 1'b1;
            end
            DMA_HALT: begin
                rdy = 1'b0;
            end
            DMA_ALIGN, DMA_READ: begin
                dma_active = 1'b1;
                dma_addr   = {page_q, idx_q};
            end
            DMA_WRITE: begin
                dma_active = 1'b1;
                dma_addr   = OAMDATA_REG;
                dma_we     = 1'b1;
                dma_dout   = data_q;
            end
            default: begin
                rdy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_oam_dma;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  bus_din;
    logic        rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_dout;

    int errors;
    int checks;
    int cyc;

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_we     (cpu_we),
        .bus_din    (bus_din),
        .rdy        (rdy),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_we     (dma_we),
        .dma_dout   (dma_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: page $02 holds i ^ $A5; other pages are mixed with the page number
    assign bus_din = dma_addr[7:0] ^ 8'hA5 ^ ((dma_addr[15:8] == 8'h02) ? 8'h00 : dma_addr[15:8]);

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".rdy"},    {15'd0, rdy},        16'd1);
        chk({tag, ".active"}, {15'd0, dma_active}, 16'd0);
        chk({tag, ".we"},     {15'd0, dma_we},     16'd0);
    endtask

    // Runs one transfer starting in the current (idle) cycle.
    // stall: HALT cycles with cpu_we still high; retrig_at: READ index at which a
    // $03 trigger is injected (256 = during the final WRITE, -1 = none);
    // abort_at: WRITE index at which rst is pulsed (-1 = none).
    task automatic do_xfer(input logic [7:0] pg, input int stall, input int retrig_at,
                           input int abort_at, input int exp_halted);
        int halted;
        bit align;
        halted = 0;
        cpu_we   = 1'b1;
        cpu_addr = 16'h4014;
        cpu_dout = pg;
        tick();
        cpu_addr = 16'h0100;
        cpu_dout = 8'h00;
        for (int s = 0; s < stall; s++) begin
            cpu_we = 1'b1;
            chk("halt_stall.rdy", {15'd0, rdy}, 16'd0);
            chk("halt_stall.active", {15'd0, dma_active}, 16'd0);
            chk("halt_stall.addr", dma_addr, 16'h0000);
            halted = halted + 1;
            tick();
        end
        cpu_we = 1'b0;
        chk("halt.rdy", {15'd0, rdy}, 16'd0);
        chk("halt.active", {15'd0, dma_active}, 16'd0);
        halted = halted + 1;
        align = cyc[0];
        tick();
        if (align) begin
            chk("align.rdy", {15'd0, rdy}, 16'd0);
            chk("align.active", {15'd0, dma_active}, 16'd1);
            chk("align.we", {15'd0, dma_we}, 16'd0);
            chk("align.addr", dma_addr, {pg, 8'h00});
            halted = halted + 1;
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            chk("read.rdy", {15'd0, rdy}, 16'd0);
            chk("read.active", {15'd0, dma_active}, 16'd1);
            chk("read.we", {15'd0, dma_we}, 16'd0);
            chk("read.addr", dma_addr, {pg, i[7:0]});
            halted = halted + 1;
            if (i == retrig_at) begin
                cpu_we   = 1'b1;
                cpu_addr = 16'h4014;
                cpu_dout = 8'h03;
            end
            tick();
            cpu_we   = 1'b0;
            cpu_addr = 16'h0100;
            chk("write.rdy", {15'd0, rdy}, 16'd0);
            chk("write.we", {15'd0, dma_we}, 16'd1);
            chk("write.addr", dma_addr, 16'h2004);
            chk("write.data", {8'd0, dma_dout}, {8'd0, i[7:0] ^ 8'hA5});
            halted = halted + 1;
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                cyc = 0;
                chk_idle("abort");
                chk("abort.addr", dma_addr, 16'h0000);
                chk("abort.dout", {8'd0, dma_dout}, 16'h0000);
                return;
            end
            if (i == 255 && retrig_at == 256) begin
                cpu_we   = 1'b1;
                cpu_addr = 16'h4014;
                cpu_dout = 8'h03;
            end
            tick();
            cpu_we   = 1'b0;
            cpu_addr = 16'h0100;
        end
        chk_idle("done");
        chk("halted_cycles", halted[15:0], exp_halted[15:0]);
        if (retrig_at == 256) begin
            tick();
            chk_idle("final_retrig_ignored");
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        rst      = 1'b1;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        cpu_we   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;

        chk_idle("reset");
        chk("reset.addr", dma_addr, 16'h0000);
        chk("reset.dout", {8'd0, dma_dout}, 16'h0000);

        for (int k = 0; k < 10; k++) begin
            tick();
            chk_idle("idle");
        end

        // HALT leaves at an even-parity cycle: no alignment, 513 halted cycles
        if (cyc[0] == 1'b0) tick();
        do_xfer(8'h02, 0, -1, -1, 513);

        // HALT leaves at an odd-parity cycle: one alignment cycle, 514 halted cycles
        if (cyc[0] == 1'b1) tick();
        do_xfer(8'h02, 0, -1, -1, 514);

        // cpu_we held for two more cycles: HALT lasts 3 cycles (no-align parity)
        if (cyc[0] == 1'b0) tick();
        do_xfer(8'h02, 2, -1, -1, 515);

        // Retrigger to page $03 mid-transfer is ignored
        tick();
        if (cyc[0] == 1'b0) tick();
        do_xfer(8'h02, 0, 100, -1, 513);

        // Trigger coincident with the final WRITE is ignored
        tick();
        if (cyc[0] == 1'b0) tick();
        do_xfer(8'h02, 0, 256, -1, 513);

        // Reset during WRITE of idx $40, then a fresh transfer restarts at idx 0
        tick();
        if (cyc[0] == 1'b0) tick();
        do_xfer(8'h02, 0, -1, 8'h40, 0);
        tick();
        chk_idle("post_abort");
        if (cyc[0] == 1'b0) tick();
        do_xfer(8'h02, 0, -1, -1, 513);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
